// File: rtl/led_pkg.sv
// Shared definitions for the LED strip driver: 12MHz timing defaults,
// FSM state encoding and a counter-width helper.
package led_pkg;

    localparam int LED_TBIT   = 15;
    localparam int LED_T0H    = 4;
    localparam int LED_T1H    = 9;
    localparam int LED_TRESET = 960;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_RESET
    } led_state_t;

    // Width of a counter holding values 0..n-1; never zero so degenerate
    // parameter choices still produce legal vectors.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_strip_driver_bit_timer.sv
// One-wire bit period generator: counts 0..TBIT-1 and drives the line high
// for T1H or T0H clocks depending on the bit value.
module ws2812_bit_timer
    import led_pkg::*;
#(
    parameter int TBIT = LED_TBIT,
    parameter int T0H  = LED_T0H,
    parameter int T1H  = LED_T1H
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    input  logic bit_val,
    output logic dout,
    output logic bit_end
);

    localparam int            TW    = cnt_width(TBIT);
    localparam logic [TW-1:0] LAST  = TW'(TBIT - 1);
    localparam logic [TW-1:0] HIGH0 = TW'(T0H);
    localparam logic [TW-1:0] HIGH1 = TW'(T1H);

    logic [TW-1:0] timer;

    // Bit-period counter: restart zeroes it, otherwise it wraps at TBIT-1 while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (restart) begin
            timer <= '0;
        end else if (en) begin
            timer <= (timer == LAST) ? '0 : timer + 1'b1;
        end
    end

    // High/low compare; the line is held low whenever the timer is not running
    always_comb begin
        bit_end = en && (timer == LAST);
        dout    = en && (timer < (bit_val ? HIGH1 : HIGH0));
    end

endmodule

// File: rtl/led_strip_driver.sv
// WS2812-style strip driver: fetches NLEDS pixels from the frame RAM,
// serialises them MSB first with gapless bits, then holds a latch gap.
module led_strip_driver
    import led_pkg::*;
#(
    parameter int BITS   = 24,
    parameter int NLEDS  = 256,
    parameter int AWIDTH = cnt_width(NLEDS),
    parameter int TBIT   = LED_TBIT,
    parameter int T0H    = LED_T0H,
    parameter int T1H    = LED_T1H,
    parameter int TRESET = LED_TRESET
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              re,
    output logic [AWIDTH-1:0] raddr,
    input  logic [BITS-1:0]   rdata,
    output logic              dout
);

    localparam int                BW       = cnt_width(BITS);
    localparam int                GW       = cnt_width(TRESET);
    localparam logic [BW-1:0]     TOP_BIT  = BW'(BITS - 1);
    localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(NLEDS - 1);
    localparam logic [GW-1:0]     GAP_LOAD = GW'(TRESET - 1);

    led_state_t        state, state_nxt;
    logic [BITS-1:0]   shift, shift_nxt;
    logic [BW-1:0]     bit_idx, bit_nxt;
    logic [AWIDTH-1:0] pix_idx, pix_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic              re_nxt;
    logic [AWIDTH-1:0] raddr_nxt;
    logic              tmr_en, tmr_restart, bit_end;

    ws2812_bit_timer #(
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .restart (tmr_restart),
        .bit_val (shift[BITS-1]),
        .dout    (dout),
        .bit_end (bit_end)
    );

    assign busy = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, datapath updates and read-port requests
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_nxt     = bit_idx;
        pix_nxt     = pix_idx;
        gap_nxt     = gap_cnt;
        re_nxt      = 1'b0;
        raddr_nxt   = raddr;
        tmr_en      = 1'b0;
        tmr_restart = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    re_nxt    = 1'b1;
                    raddr_nxt = '0;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt   = ST_SEND;
                shift_nxt   = rdata;
                bit_nxt     = TOP_BIT;
                pix_nxt     = '0;
                tmr_restart = 1'b1;
                // Prefetch pixel 1 during the first clock of pixel 0
                if (NLEDS > 1) begin
                    re_nxt    = 1'b1;
                    raddr_nxt = AWIDTH'(1);
                end
            end
            ST_SEND: begin
                tmr_en = 1'b1;
                if (bit_end) begin
                    if (bit_idx != '0) begin
                        shift_nxt = shift << 1;
                        bit_nxt   = bit_idx - 1'b1;
                    end else if (pix_idx == LAST_PIX) begin
                        state_nxt = ST_RESET;
                        gap_nxt   = GAP_LOAD;
                    end else begin
                        // rdata still holds the prefetched next pixel
                        shift_nxt = rdata;
                        bit_nxt   = TOP_BIT;
                        pix_nxt   = pix_idx + 1'b1;
                        if ((pix_idx + 1'b1) != LAST_PIX) begin
                            re_nxt    = 1'b1;
                            raddr_nxt = pix_idx + AWIDTH'(2);
                        end
                    end
                end
            end
            ST_RESET: begin
                if (gap_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and the registered RAM read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= '0;
            bit_idx <= '0;
            pix_idx <= '0;
            gap_cnt <= '0;
            re      <= 1'b0;
            raddr   <= '0;
        end else begin
            shift   <= shift_nxt;
            bit_idx <= bit_nxt;
            pix_idx <= pix_nxt;
            gap_cnt <= gap_nxt;
            re      <= re_nxt;
            raddr   <= raddr_nxt;
        end
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// Bench for led_strip_driver with a small frame: expected line waveform is
// built from the pixel values and the bit-timing rules, cycle by cycle.
module tb_led_strip_driver;

    localparam int BITS       = 4;
    localparam int NLEDS      = 2;
    localparam int AW         = 1;
    localparam int TBIT       = 6;
    localparam int T0H        = 2;
    localparam int T1H        = 4;
    localparam int TRESET     = 10;
    localparam int PIX_CLKS   = BITS * TBIT;
    localparam int FRAME_CLKS = NLEDS * PIX_CLKS + TRESET;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, re, dout;
    logic [AW-1:0]   raddr;
    logic [BITS-1:0] rdata;
    logic [BITS-1:0] mem [NLEDS];
    bit              exp_q[$];
    int              checks = 0;
    int              errors = 0;

    led_strip_driver #(
        .BITS   (BITS),
        .NLEDS  (NLEDS),
        .AWIDTH (AW),
        .TBIT   (TBIT),
        .T0H    (T0H),
        .T1H    (T1H),
        .TRESET (TRESET)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // Frame RAM read port: data one clock after re, held otherwise
    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, got, want);
        end
    endtask

    // Expected line level for every clock from the first rise to the end of the gap
    task automatic build_model();
        exp_q.delete();
        for (int p = 0; p < NLEDS; p++) begin
            for (int b = BITS - 1; b >= 0; b--) begin
                int hi;
                hi = mem[p][b] ? T1H : T0H;
                for (int t = 0; t < TBIT; t++) exp_q.push_back(t < hi);
            end
        end
        for (int t = 0; t < TRESET; t++) exp_q.push_back(1'b0);
    endtask

    // Entered at a falling edge with the DUT idle; leaves at the falling edge
    // of the idle cycle after done. mid_at: frame clock at which to pulse start.
    task automatic run_frame(input string tag, input bit hold, input int mid_at);
        int re_cnt;
        bit exp_re;
        build_model();
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk(tag, "fetch_re", re, 1);
        chk(tag, "fetch_raddr", raddr, 0);
        chk(tag, "fetch_busy", busy, 1);
        chk(tag, "fetch_dout", dout, 0);
        re_cnt = re;
        @(negedge clk);
        chk(tag, "load_re", re, 0);
        chk(tag, "load_dout", dout, 0);
        for (int c = 0; c < FRAME_CLKS; c++) begin
            @(negedge clk);
            if (!hold) start = (c == mid_at);
            exp_re = ((c % PIX_CLKS) == 0) && ((c / PIX_CLKS) < NLEDS - 1);
            chk(tag, $sformatf("dout@%0d", c), dout, exp_q[c]);
            chk(tag, $sformatf("re@%0d", c), re, exp_re);
            if (exp_re) chk(tag, $sformatf("raddr@%0d", c), raddr, c / PIX_CLKS + 1);
            chk(tag, $sformatf("done@%0d", c), done, (c == FRAME_CLKS - 1));
            chk(tag, $sformatf("busy@%0d", c), busy, 1);
            re_cnt += re;
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk(tag, "idle_busy", busy, 0);
        chk(tag, "idle_done", done, 0);
        chk(tag, "idle_dout", dout, 0);
        chk(tag, "raddr_hold", raddr, NLEDS - 1);
        chk(tag, "re_pulses", re_cnt, NLEDS);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NLEDS; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset", "dout", dout, 0);
        chk("reset", "re", re, 0);
        chk("reset", "raddr", raddr, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset", "idle_busy", busy, 0);

        mem[0] = 4'hA;
        mem[1] = 4'h5;
        run_frame("a5", 1'b0, -1);
        @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NLEDS; i++) mem[i] = 4'($urandom);
            run_frame($sformatf("rnd%0d", n), 1'b0, $urandom_range(0, FRAME_CLKS - 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < NLEDS; i++) mem[i] = 4'($urandom);
        run_frame("start_on_done", 1'b0, FRAME_CLKS - 1);
        @(negedge clk);
        chk("start_on_done", "still_idle", busy, 0);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NLEDS; i++) mem[i] = 4'($urandom);
            run_frame($sformatf("b2b%0d", n), 1'b1, -1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b", "released_idle", busy, 0);

        for (int i = 0; i < NLEDS; i++) mem[i] = '1;
        run_frame("ones", 1'b0, -1);
        for (int i = 0; i < NLEDS; i++) mem[i] = '0;
        run_frame("zeros", 1'b0, -1);
        @(negedge clk);

        mem[0] = 4'($urandom);
        mem[1] = 4'($urandom) | 4'b0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        repeat (PIX_CLKS + TBIT + 2) @(negedge clk);
        chk("midrst", "pre_dout", dout, 1);
        chk("midrst", "pre_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst", "dout", dout, 0);
        chk("midrst", "re", re, 0);
        chk("midrst", "busy", busy, 0);
        chk("midrst", "done", done, 0);
        chk("midrst", "raddr", raddr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst", "idle_dout", dout, 0);
        chk("midrst", "idle_busy", busy, 0);
        run_frame("after_rst", 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
